// File: rtl/zcu104_main_blk_pkg.sv
// Shared constants and state types for the ZCU104 main block: address windows,
// CTRL register layout, AXI response codes and both FSM state encodings.
package zcu104_main_blk_pkg;

  localparam logic [31:0] MST_BASE_DEF = 32'hA000_0000;
  localparam logic [31:0] IMG_BASE_DEF = 32'hA001_0000;
  localparam logic [31:0] WIN_SIZE     = 32'h0001_0000;
  localparam logic [31:0] WIN_MASK     = ~(WIN_SIZE - 32'd1);

  localparam logic [15:0] CTRL_OFS       = 16'h0010;
  localparam int          CTRL_START_BIT = 0;
  localparam int          CTRL_SRST_BIT  = 1;
  localparam int          CTRL_AUTO_BIT  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BEAT_BYTES = 16;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {S_IDLE, S_RUN}          st_state_e;
  typedef enum logic [1:0] {WIN_DEC, WIN_MST, WIN_IMG} win_e;

endpackage

// File: rtl/zcu104_img_buffer.sv
// Image storage: simple dual-port RAM, 128-bit words, byte write enables,
// registered read (data for raddr_i appears one cycle later).
import zcu104_main_blk_pkg::*;

module zcu104_img_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [127:0]          wdata_i,
  input  logic [BEAT_BYTES-1:0] wstrb_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [127:0]          rdata_o
);

  logic [127:0] mem_q [DEPTH];

  // Byte-masked write port and registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/zcu104_main_blk.sv
// ZCU104 main block: AXI write slave with a master-control window (CTRL at
// offset 0x10) and an image-data window filling a frame buffer, plus an
// AXI-Stream engine replaying the buffered frame.
// Optional build macro: ZCU104_MAIN_BLK_OVF_ERR_EN -- image writes that drop
// beats on a full buffer answer SLVERR instead of OKAY.
import zcu104_main_blk_pkg::*;

module zcu104_main_blk #(
  parameter int          IMG_DEPTH   = 256,
  parameter logic [31:0] MASTER_BASE = MST_BASE_DEF,
  parameter logic [31:0] IMAGE_BASE  = IMG_BASE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_axi_awaddr,
  input  logic [7:0]   s_axi_awlen,
  input  logic [2:0]   s_axi_awsize,
  input  logic [1:0]   s_axi_awburst,
  input  logic         s_axi_awvalid,
  output logic         s_axi_awready,
  input  logic [127:0] s_axi_wdata,
  input  logic [15:0]  s_axi_wstrb,
  input  logic         s_axi_wlast,
  input  logic         s_axi_wvalid,
  output logic         s_axi_wready,
  output logic [1:0]   s_axi_bresp,
  output logic         s_axi_bvalid,
  input  logic         s_axi_bready,
  output logic [127:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tuser,
  output logic         m_axis_tlast,
  output logic         busy
);

  localparam int         PW      = $clog2(IMG_DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(IMG_DEPTH);
  localparam logic [PW:0] ONE_W   = (PW+1)'(1);
`ifdef ZCU104_MAIN_BLK_OVF_ERR_EN
  localparam bit OVF_ERR = 1'b1;
`else
  localparam bit OVF_ERR = 1'b0;
`endif

  // Burst length/size/type do not matter: wlast ends every transaction.
  logic unused_aw;
  assign unused_aw = ^{s_axi_awlen, s_axi_awsize, s_axi_awburst};

  wr_state_e     wst_q;
  win_e          win_q, aw_win;
  logic          mst_ok_q, drop_q;
  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q, resp_d;
  logic          srst_q, auto_q, start_q;
  logic [PW:0]   wr_ptr_q;
  logic          ovf_q;
  st_state_e     sst_q, sst_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   flen_q, flen_d;
  logic [127:0]  rdata;
  logic          w_fire, img_fire, full, img_drop, ctrl_we, last_pos;

  // Decode which window the incoming write address falls into.
  always_comb begin
    aw_win = WIN_DEC;
    if ((s_axi_awaddr & WIN_MASK) == MASTER_BASE)     aw_win = WIN_MST;
    else if ((s_axi_awaddr & WIN_MASK) == IMAGE_BASE) aw_win = WIN_IMG;
  end

  assign w_fire   = wready_q && s_axi_wvalid;
  assign img_fire = w_fire && (win_q == WIN_IMG) && !srst_q;
  assign full     = (wr_ptr_q == DEPTH_W);
  assign img_drop = img_fire && full;
  // Only the final beat of a CTRL burst lands, and only if byte 0 is enabled.
  assign ctrl_we  = w_fire && s_axi_wlast && (win_q == WIN_MST) && mst_ok_q && s_axi_wstrb[0];

  // Response code for the transaction, including a drop on the final beat.
  always_comb begin
    resp_d = RESP_OKAY;
    case (win_q)
      WIN_DEC: resp_d = RESP_DECERR;
      WIN_MST: if (!mst_ok_q) resp_d = RESP_SLVERR;
      WIN_IMG: if (OVF_ERR && (drop_q || img_drop)) resp_d = RESP_SLVERR;
      default: resp_d = RESP_OKAY;
    endcase
  end

  // Write FSM: one transaction at a time, handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q     <= W_IDLE;
      win_q     <= WIN_DEC;
      mst_ok_q  <= 1'b0;
      drop_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wst_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s_axi_awvalid) begin
            win_q     <= aw_win;
            mst_ok_q  <= (s_axi_awaddr[15:0] == CTRL_OFS);
            drop_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wst_q     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            drop_q <= drop_q | img_drop;
            if (s_axi_wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= resp_d;
              wst_q    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wst_q     <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  // CTRL register: SRST/AUTO are levels, START is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      srst_q  <= 1'b0;
      auto_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (ctrl_we) begin
        srst_q  <= s_axi_wdata[CTRL_SRST_BIT];
        auto_q  <= s_axi_wdata[CTRL_AUTO_BIT];
        start_q <= s_axi_wdata[CTRL_START_BIT] && !s_axi_wdata[CTRL_SRST_BIT];
      end
    end
  end

  // Write pointer and sticky overflow; SRST holds both cleared.
  always_ff @(posedge clk) begin
    if (rst || srst_q) begin
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (img_fire) begin
      if (full) ovf_q    <= 1'b1;
      else      wr_ptr_q <= wr_ptr_q + ONE_W;
    end
  end

  assign last_pos = ({1'b0, rd_ptr_q} == flen_q - ONE_W);

  // Stream next state; rd_ptr_d feeds the RAM so its output tracks rd_ptr_q.
  always_comb begin
    sst_d    = sst_q;
    rd_ptr_d = rd_ptr_q;
    flen_d   = flen_q;
    if (srst_q) begin
      sst_d    = S_IDLE;
      rd_ptr_d = '0;
    end else begin
      case (sst_q)
        S_IDLE: if (start_q && (wr_ptr_q != '0)) begin
          flen_d   = wr_ptr_q;
          rd_ptr_d = '0;
          sst_d    = S_RUN;
        end
        S_RUN: if (m_axis_tready) begin
          if (last_pos) begin
            rd_ptr_d = '0;
            sst_d    = auto_q ? S_RUN : S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
        default: sst_d = S_IDLE;
      endcase
    end
  end

  // Stream state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sst_q    <= S_IDLE;
      rd_ptr_q <= '0;
      flen_q   <= '0;
    end else begin
      sst_q    <= sst_d;
      rd_ptr_q <= rd_ptr_d;
      flen_q   <= flen_d;
    end
  end

  zcu104_img_buffer #(.DEPTH(IMG_DEPTH), .AW(PW)) u_buf (
    .clk_i   (clk),
    .we_i    (img_fire && !full),
    .waddr_i (wr_ptr_q[PW-1:0]),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .raddr_i (rd_ptr_d),
    .rdata_o (rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign m_axis_tvalid = (sst_q == S_RUN);
  assign m_axis_tdata  = m_axis_tvalid ? rdata : '0;
  assign m_axis_tuser  = m_axis_tvalid && (rd_ptr_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && last_pos;
  assign busy          = m_axis_tvalid;

endmodule

// File: tb/tb_zcu104_main_blk.sv
// Directed bench for zcu104_main_blk: a default-depth instance and a
// 16-word instance share all inputs so the overflow case can be exercised.
module tb_zcu104_main_blk;

  localparam logic [31:0] MST  = 32'hA000_0000;
  localparam logic [31:0] IMG  = 32'hA001_0000;
  localparam logic [31:0] CTRL = 32'hA000_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic [2:0]   awsize = 3'd4;
  logic [1:0]   awburst = 2'b00;
  logic         awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, tready = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;

  logic awready, wready, bvalid, tvalid, tuser, tlast, busy;
  logic [1:0]   bresp;
  logic [127:0] tdata;
  logic awready_b, wready_b, bvalid_b, tvalid_b, tuser_b, tlast_b, busy_b;
  logic [1:0]   bresp_b;
  logic [127:0] tdata_b;

  zcu104_main_blk dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .busy(busy)
  );

  zcu104_main_blk #(.IMG_DEPTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready_b),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready_b),
    .s_axi_bresp(bresp_b), .s_axi_bvalid(bvalid_b), .s_axi_bready(bready),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready),
    .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b), .busy(busy_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  logic [127:0] wbuf [32];

  function automatic logic [127:0] pat(input int base, input int i);
    return {4{32'(base + i)}};
  endfunction

  // One full AXI write; beat i carries wbuf[i]. Returns both instances' bresp.
  task automatic axi_wr(input logic [31:0] addr, input int nb, input logic [15:0] strb,
                        output logic [1:0] resp, output logic [1:0] resp16);
    int g;
    awaddr = addr; awlen = 8'(nb - 1); awvalid = 1'b1;
    g = 0;
    while (!awready && g < 50) begin @(negedge clk); g++; end
    chk("aw_handshake", 128'(g < 50), 128'(1));
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == nb - 1); wvalid = 1'b1;
      g = 0;
      while (!wready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) chk("w_handshake", 128'(g), 128'(0));
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    g = 0;
    while (!bvalid && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("b_handshake", 128'(g), 128'(0));
    resp = bresp; resp16 = bresp_b;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [127:0] v, output logic [1:0] resp);
    logic [1:0] rb;
    wbuf[0] = v;
    axi_wr(CTRL, 1, 16'hFFFF, resp, rb);
  endtask

  // Stream monitor: records handshaken beats and checks tdata holds across stalls.
  bit           mon_en = 1'b0;
  int           nbeat = 0;
  int           stall_err = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic [127:0] bdata [64];
  logic         buser [64];
  logic         blast [64];

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall && tvalid && tdata !== prev_data) stall_err++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      if (tvalid && tready && nbeat < 64) begin
        bdata[nbeat] = tdata; buser[nbeat] = tuser; blast[nbeat] = tlast;
        nbeat++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

  initial begin
    logic [1:0] r, rb;
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready",  wready, 0);
    chk("rst_bvalid",  bvalid, 0);
    chk("rst_bresp",   bresp, 0);
    chk("rst_tvalid",  tvalid, 0);
    chk("rst_tuser",   tuser, 0);
    chk("rst_tlast",   tlast, 0);
    chk("rst_tdata",   tdata, 0);
    chk("rst_busy",    busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("awready_rise", awready, 1);

    // 16-beat FIXED burst of all-ones into the image window
    for (int i = 0; i < 16; i++) wbuf[i] = '1;
    axi_wr(IMG, 16, 16'hFFFF, r, rb);
    chk("t1_bresp", r, 2'b00);
    chk("t1_wr_ptr", dut.wr_ptr_q, 16);

    // SRST then release
    ctrl_wr(128'h2, r);
    ctrl_wr(128'h0, r);
    chk("t2_wr_ptr", dut.wr_ptr_q, 0);
    chk("t2_busy", busy, 0);
    chk("t2_tvalid", tvalid, 0);

    // AUTO loop with tready held high
    for (int i = 0; i < 16; i++) wbuf[i] = pat(32'h1000, i);
    axi_wr(IMG, 16, 16'hFFFF, r, rb);
    tready = 1'b1; nbeat = 0; prev_stall = 1'b0; mon_en = 1'b1;
    ctrl_wr(128'h9, r);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_busy", busy, 1);
    mon_en = 1'b0;
    chk("t3_cnt", 128'(nbeat >= 17), 128'(1));
    chk("t3_d0", bdata[0], pat(32'h1000, 0));
    chk("t3_user0", buser[0], 1);
    chk("t3_last0", blast[0], 0);
    chk("t3_user1", buser[1], 0);
    chk("t3_d7", bdata[7], pat(32'h1000, 7));
    chk("t3_last14", blast[14], 0);
    chk("t3_last15", blast[15], 1);
    chk("t3_d15", bdata[15], pat(32'h1000, 15));
    chk("t3_user16", buser[16], 1);
    chk("t3_d16", bdata[16], pat(32'h1000, 0));
    ctrl_wr(128'h2, r);
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_tvalid", tvalid, 0);
    ctrl_wr(128'h0, r);

    // Single frame with tready toggling every cycle
    tready = 1'b0;
    for (int i = 0; i < 16; i++) wbuf[i] = pat(32'h2000, i);
    axi_wr(IMG, 16, 16'hFFFF, r, rb);
    nbeat = 0; stall_err = 0; prev_stall = 1'b0; mon_en = 1'b1;
    fork
      ctrl_wr(128'h1, r);
      begin
        repeat (70) begin @(posedge clk); #1 tready = ~tready; end
      end
    join
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b0;
    tready = 1'b0;
    chk("t4_cnt", nbeat, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t4_d%0d", i), bdata[i], pat(32'h2000, i));
    chk("t4_last15", blast[15], 1);
    chk("t4_stall_hold", stall_err, 0);
    chk("t4_busy", busy, 0);

    // Error responses and CTRL write qualification
    wbuf[0] = 128'h8;
    axi_wr(32'hB000_0000, 1, 16'hFFFF, r, rb);
    chk("t5_decerr", r, 2'b11);
    axi_wr(MST + 32'h4, 1, 16'hFFFF, r, rb);
    chk("t5_slverr", r, 2'b10);
    chk("t5_ctrl_keep", dut.auto_q, 0);
    axi_wr(CTRL, 1, 16'hFFFE, r, rb);
    chk("t5_strb0_resp", r, 2'b00);
    chk("t5_strb0_keep", dut.auto_q, 0);
    wbuf[0] = 128'h8; wbuf[1] = 128'h0;
    axi_wr(CTRL, 2, 16'hFFFF, r, rb);
    chk("t5_burst_last0", dut.auto_q, 0);
    wbuf[0] = 128'h0; wbuf[1] = 128'h8;
    axi_wr(CTRL, 2, 16'hFFFF, r, rb);
    chk("t5_burst_last8", dut.auto_q, 1);
    ctrl_wr(128'h0, r);

    // Overflow: 20 beats into a 16-word buffer
    ctrl_wr(128'h2, r);
    ctrl_wr(128'h0, r);
    for (int i = 0; i < 20; i++) wbuf[i] = pat(32'h3000, i);
    axi_wr(IMG, 20, 16'hFFFF, r, rb);
    chk("t6_big_bresp", r, 2'b00);
    chk("t6_big_wr_ptr", dut.wr_ptr_q, 20);
    chk("t6_big_ovf", dut.ovf_q, 0);
    chk("t6_small_wr_ptr", dut16.wr_ptr_q, 16);
    chk("t6_small_ovf", dut16.ovf_q, 1);
`ifdef ZCU104_MAIN_BLK_OVF_ERR_EN
    chk("t6_small_bresp", rb, 2'b10);
`else
    chk("t6_small_bresp", rb, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
